// File: rtl/nlp_fir_coeff_seq.sv
// Coefficient sequencer for a symmetric 48-tap low-pass FIR: streams the sign-magnitude
// table over a valid/ready handshake and serves a registered random-access read port.
// Optional build macro: NLP_FIR_TWOS_COMP_EN presents both data outputs as two's complement.
module nlp_fir_coeff_seq #(
    parameter int N     = 80,
    parameter int DEPTH = 48,
    parameter int AW    = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_dir,
    input  logic          i_ready,
    output logic          o_coeff_valid,
    output logic [N-1:0]  o_coeff_data,
    output logic [AW-1:0] o_coeff_idx,
    output logic          o_coeff_last,
    output logic          o_busy,
    input  logic [AW-1:0] i_rd_addr,
    output logic [N-1:0]  o_rd_data
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [AW-1:0] LP_FIRST = AW'(0);
    localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);
    localparam logic [AW:0]   LP_DEPTH = (AW + 1)'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_dir;
    logic          w_dir_nxt;
    logic [AW-1:0] r_coeff_idx;
    logic [AW-1:0] w_idx_nxt;
    logic          r_coeff_valid;
    logic          r_coeff_last;
    logic          r_busy;
    logic [N-1:0]  r_coeff_data;
    logic [N-1:0]  r_rd_data;
    logic          w_accept;
    logic          w_valid_nxt;
    logic          w_last_nxt;
    logic [N-1:0]  w_data_nxt;
    logic          w_rd_in_range;

    // Magnitudes of the first half of the symmetric response, LSB = 2^-16.
    function automatic logic [15:0] tap_mag(input int j);
        logic [15:0] m;
        case (j)
            0:       m = 16'd70;
            1:       m = 16'd72;
            2:       m = 16'd60;
            3:       m = 16'd27;
            4:       m = 16'd36;
            5:       m = 16'd131;
            6:       m = 16'd242;
            7:       m = 16'd337;
            8:       m = 16'd366;
            9:       m = 16'd282;
            10:      m = 16'd52;
            11:      m = 16'd315;
            12:      m = 16'd767;
            13:      m = 16'd1192;
            14:      m = 16'd1446;
            15:      m = 16'd1371;
            16:      m = 16'd839;
            17:      m = 16'd211;
            18:      m = 16'd1748;
            19:      m = 16'd3638;
            20:      m = 16'd5656;
            21:      m = 16'd7523;
            22:      m = 16'd8961;
            default: m = 16'd9743;
        endcase
        return m;
    endfunction

    function automatic logic tap_neg(input int j);
        return (((j >= 0) && (j <= 3)) || ((j >= 11) && (j <= 16))) ? 1'b1 : 1'b0;
    endfunction

    // Fold the index onto the first half so tap k equals tap DEPTH-1-k.
    function automatic logic [N-1:0] tap_word(input logic [AW-1:0] k);
        int ki;
        int j;
        ki = int'(k);
        if ((2 * ki) < DEPTH) begin
            j = ki;
        end else begin
            j = DEPTH - 1 - ki;
        end
        if (j < 0) begin
            j = 0;
        end else begin
            j = j;
        end
        return {tap_neg(j), (N - 1)'(tap_mag(j))};
    endfunction

    function automatic logic [N-1:0] present(input logic [N-1:0] sm);
`ifdef NLP_FIR_TWOS_COMP_EN
        logic [N-1:0] mag_ext;
        mag_ext = {1'b0, sm[N-2:0]};
        // Negative zero negates to zero, so it needs no special case.
        if (sm[N-1]) begin
            return (~mag_ext) + N'(1);
        end else begin
            return mag_ext;
        end
`else
        return sm;
`endif
    endfunction

    assign w_accept      = r_coeff_valid & i_ready;
    assign w_rd_in_range = ({1'b0, i_rd_addr} < LP_DEPTH);

    // State register and latched stream direction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Next-state, direction and index selection.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_idx_nxt   = r_coeff_idx;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_STREAM;
                    w_dir_nxt   = i_dir;
                    w_idx_nxt   = i_dir ? LP_LAST : LP_FIRST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // start is deliberately not looked at here, even on the final beat.
                if (w_accept) begin
                    if (r_coeff_last) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_dir) begin
                        w_idx_nxt = r_coeff_idx - AW'(1);
                    end else begin
                        w_idx_nxt = r_coeff_idx + AW'(1);
                    end
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered stream outputs.
    always_comb begin
        w_valid_nxt = (w_state_nxt == ST_STREAM);
        w_last_nxt  = 1'b0;
        w_data_nxt  = present(tap_word(w_idx_nxt));
        if (w_valid_nxt) begin
            w_last_nxt = (w_idx_nxt == (w_dir_nxt ? LP_FIRST : LP_LAST));
        end else begin
            w_last_nxt = 1'b0;
        end
    end

    // Stream output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_coeff_valid <= 1'b0;
            r_coeff_last  <= 1'b0;
            r_busy        <= 1'b0;
            r_coeff_idx   <= LP_FIRST;
            r_coeff_data  <= {N{1'b0}};
        end else begin
            r_coeff_valid <= w_valid_nxt;
            r_coeff_last  <= w_last_nxt;
            r_busy        <= w_valid_nxt;
            r_coeff_idx   <= w_idx_nxt;
            r_coeff_data  <= w_data_nxt;
        end
    end

    // Random-access read port, independent of the stream.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= {N{1'b0}};
        end else if (w_rd_in_range) begin
            r_rd_data <= present(tap_word(i_rd_addr));
        end else begin
            r_rd_data <= {N{1'b0}};
        end
    end

    assign o_coeff_valid = r_coeff_valid;
    assign o_coeff_data  = r_coeff_data;
    assign o_coeff_idx   = r_coeff_idx;
    assign o_coeff_last  = r_coeff_last;
    assign o_busy        = r_busy;
    assign o_rd_data     = r_rd_data;

endmodule

// File: doc/nlp_fir_coeff_seq.md
NLP_FIR_COEFF_SEQ -- requirements
Module: nlp_fir_coeff_seq

Interface
REQ-001 Parameter N, default 80: coefficient word width in bits, with the sign in the MSB and the magnitude in bits [N-2:0].
REQ-002 Parameter DEPTH, default 48: number of taps, 2..64.
REQ-003 Parameter AW, default 6: address and index width; the integrator sets it to ceil(log2(DEPTH)).
REQ-004 clk  in  1  sole clock; all logic updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request a full coefficient stream.
REQ-007 dir  in  1  stream order, sampled with start: 0 ascending (0..DEPTH-1), 1 descending (DEPTH-1..0).
REQ-008 ready  in  1  downstream accepts the current beat.
REQ-009 coeff_valid  out  1  coeff_data, coeff_idx and coeff_last are valid.
REQ-010 coeff_data  out  N  coefficient at coeff_idx.
REQ-011 coeff_idx  out  AW  tap index of the current beat.
REQ-012 coeff_last  out  1  final beat of the stream.
REQ-013 busy  out  1  high while a stream is in progress.
REQ-014 rd_addr  in  AW  random-access read address.
REQ-015 rd_data  out  N  registered random-access read data.

Function
REQ-016 Default table, DEPTH=48: taps 0..23 magnitudes are 70, 72, 60, 27, 36, 131, 242, 337, 366, 282, 52, 315, 767, 1192, 1446, 1371, 839, 211, 1748, 3638, 5656, 7523, 8961, 9743 (LSB = 2^-16).
REQ-017 Taps 0-3 and 11-16 of the default table are negative; all other taps 0..23 are positive.
REQ-018 Default-table taps 24..47 mirror taps 23..0, so tap k equals tap 47-k.
REQ-019 The FSM has two states, IDLE and STREAM.
REQ-020 In IDLE, start=1 latches dir and moves the FSM to STREAM on the next edge.
REQ-021 The first beat is presented one cycle after start is sampled: coeff_valid=1 and coeff_idx=0 (dir=0) or DEPTH-1 (dir=1).
REQ-022 A beat is accepted when coeff_valid and ready are both 1; the index then advances by one in the selected direction on that edge.
REQ-023 While coeff_valid=1 and ready=0, coeff_data, coeff_idx and coeff_last hold stable.
REQ-024 With ready held at 1, the block streams one beat per cycle with no bubbles, DEPTH beats in total.
REQ-025 coeff_last=1 exactly on the beat with index DEPTH-1 (dir=0) or index 0 (dir=1).
REQ-026 When the last beat is accepted, coeff_valid falls and the FSM returns to IDLE on the same edge.
REQ-027 busy=1 in STREAM and 0 in IDLE.
REQ-028 start is ignored in STREAM, including the cycle in which the last beat is accepted; dir is not re-sampled mid-stream.
REQ-029 When start is ignored, the block takes no action and does not queue the request.
REQ-030 rd_data equals table[rd_addr] one cycle after rd_addr is presented; rd_addr >= DEPTH yields all zeros.
REQ-031 The random-access port operates independently of, and concurrently with, the stream.
REQ-032 Neither the stream index nor rd_addr wraps past table bounds.

Reset
REQ-033 rst=1 forces IDLE, coeff_valid=0, coeff_last=0, busy=0, coeff_idx=0, coeff_data=0 and rd_data=0 on the next edge.
REQ-034 A reset asserted mid-stream aborts the stream with no further beats.
REQ-035 After rst deasserts, the first start is accepted normally.

Configuration
REQ-036 When NLP_FIR_TWOS_COMP_EN is defined, coeff_data and rd_data are presented as N-bit two's complement of the stored sign-magnitude value.
REQ-037 A stored negative zero converts to 0 when NLP_FIR_TWOS_COMP_EN is defined.
REQ-038 When NLP_FIR_TWOS_COMP_EN is undefined, coeff_data and rd_data carry the raw sign-magnitude words.
REQ-039 Latency and handshake behaviour are identical with and without NLP_FIR_TWOS_COMP_EN.

Verification
REQ-040 Ascending stream: rst, then start=1 with dir=0 and ready=1 held -> 48 consecutive beats, idx 0..47; beat 0 data is sign=1, magnitude 70; beat 23 magnitude is 9743; coeff_last only at idx 47; busy falls after beat 47.
REQ-041 Descending stream with backpressure: dir=1, ready toggled 1,0,0,1 repeating -> idx 47..0, outputs held stable during ready=0, coeff_last at idx 0, 48 accepted beats total.
REQ-042 Stream collisions: start pulses during STREAM, including on the cycle the last beat is accepted -> no restart and no extra beats.
REQ-043 Reset mid-stream: rst=1 at idx 20 -> coeff_valid=0 and busy=0 the next cycle; a new start then yields idx 0 first.
REQ-044 Random-access port: rd_addr=12 -> rd_data has sign=1, magnitude 767 one cycle later; rd_addr=50 -> rd_data=0; both correct while a stream is running.
REQ-045 Two's complement mode, with NLP_FIR_TWOS_COMP_EN defined: tap 0 reads as -70 in N-bit two's complement and tap 23 reads as +9743.
